// File: rtl/z80fi_insn_capture.sv
// rtl/z80fi_insn_capture.sv - assembles fetched instruction bytes into a z80fi packet on retire
//
// Purpose:
//   Collects the opcode/operand bytes the core fetches for one instruction,
//   packed little-endian (first byte in z80fi_insn[7:0]), and emits one
//   registered packet (insn, len, pc, err) the cycle after the instruction retires.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   fetch_valid         one instruction byte fetched this cycle
//   fetch_first         qualifies fetch_valid: byte is the first opcode byte of a new insn
//   fetch_addr          address of the fetched byte
//   fetch_data          the fetched byte
//   retire              current instruction completed this cycle
//   z80fi_valid         one-cycle pulse, packet outputs valid
//   z80fi_insn          captured bytes, unused upper lanes zero
//   z80fi_insn_len      number of bytes captured (1..MAX_LEN)
//   z80fi_pc_rdata      address of the first opcode byte
//   z80fi_insn_err      packet malformed (overflow, orphan byte, abandoned insn, bad address)
//
// Configuration:
//   Z80FI_INSN_CAPTURE_CHECK_EN  when defined, every non-first byte must sit at pc + count
//                                (16-bit wrap); a mismatch flags the packet as erroneous.

module z80fi_insn_capture #(
  parameter int MAX_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic                 fetch_first,
  input  logic [15:0]          fetch_addr,
  input  logic [7:0]           fetch_data,
  input  logic                 retire,
  output logic                 z80fi_valid,
  output logic [8*MAX_LEN-1:0] z80fi_insn,
  output logic [2:0]           z80fi_insn_len,
  output logic [15:0]          z80fi_pc_rdata,
  output logic                 z80fi_insn_err
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_LEN);

  state_t               state_q, state_d;
  logic [8*MAX_LEN-1:0] cap_buf_q, cap_buf_d, app_buf, emit_buf;
  logic [2:0]           count_q, count_d, app_count, emit_len;
  logic [15:0]          pc_q, pc_d;
  logic                 err_q, err_d, app_err, emit_err;
  logic                 orphan_q, orphan_d;
  logic                 emit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cap_buf_q <= '0;
      count_q   <= 3'd0;
      pc_q      <= 16'd0;
      err_q     <= 1'b0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_buf_q <= cap_buf_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      orphan_q  <= orphan_d;
    end
  end

  // Effect of a non-first byte on the open instruction; used both to keep
  // collecting and to build a packet when the byte arrives with retire.
  always_comb begin
    app_buf   = cap_buf_q;
    app_count = count_q;
    app_err   = err_q;
    if (fetch_valid && !fetch_first) begin
      if (count_q >= MAX_CNT) begin
        app_err = 1'b1;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (count_q == 3'(i)) app_buf[i*8 +: 8] = fetch_data;
        end
        app_count = count_q + 3'd1;
`ifdef Z80FI_INSN_CAPTURE_CHECK_EN
        if (fetch_addr != pc_q + {13'd0, count_q}) app_err = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_buf_d = cap_buf_q;
    count_d   = count_q;
    pc_d      = pc_q;
    err_d     = err_q;
    orphan_d  = orphan_q;
    emit      = 1'b0;
    emit_buf  = cap_buf_q;
    emit_len  = count_q;
    emit_err  = err_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_valid && fetch_first) begin
          state_d        = COLLECT;
          cap_buf_d      = '0;
          cap_buf_d[7:0] = fetch_data;
          count_d        = 3'd1;
          pc_d           = fetch_addr;
          // A stray byte seen while idle taints the next packet.
          err_d          = orphan_q;
          orphan_d       = 1'b0;
        end else if (fetch_valid) begin
          orphan_d = 1'b1;
        end
      end
      COLLECT: begin
        if (fetch_valid && fetch_first) begin
          // Old insn goes out now; without retire it was abandoned.
          emit           = 1'b1;
          emit_err       = err_q | ~retire;
          cap_buf_d      = '0;
          cap_buf_d[7:0] = fetch_data;
          count_d        = 3'd1;
          pc_d           = fetch_addr;
          err_d          = 1'b0;
        end else begin
          cap_buf_d = app_buf;
          count_d   = app_count;
          err_d     = app_err;
          if (retire) begin
            emit     = 1'b1;
            emit_buf = app_buf;
            emit_len = app_count;
            emit_err = app_err;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet fields are held between pulses; only z80fi_valid pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z80fi_valid    <= 1'b0;
      z80fi_insn     <= '0;
      z80fi_insn_len <= 3'd0;
      z80fi_pc_rdata <= 16'd0;
      z80fi_insn_err <= 1'b0;
    end else begin
      z80fi_valid <= emit;
      if (emit) begin
        z80fi_insn     <= emit_buf;
        z80fi_insn_len <= emit_len;
        z80fi_pc_rdata <= pc_q;
        z80fi_insn_err <= emit_err;
      end
    end
  end

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// tb/tb_z80fi_insn_capture.sv - self-checking bench for z80fi_insn_capture

module tb_z80fi_insn_capture;

  localparam int MAX_LEN = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 fetch_valid, fetch_first, retire;
  logic [15:0]          fetch_addr;
  logic [7:0]           fetch_data;
  logic                 z80fi_valid;
  logic [8*MAX_LEN-1:0] z80fi_insn;
  logic [2:0]           z80fi_insn_len;
  logic [15:0]          z80fi_pc_rdata;
  logic                 z80fi_insn_err;

  z80fi_insn_capture #(.MAX_LEN(MAX_LEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_valid    (fetch_valid),
    .fetch_first    (fetch_first),
    .fetch_addr     (fetch_addr),
    .fetch_data     (fetch_data),
    .retire         (retire),
    .z80fi_valid    (z80fi_valid),
    .z80fi_insn     (z80fi_insn),
    .z80fi_insn_len (z80fi_insn_len),
    .z80fi_pc_rdata (z80fi_pc_rdata),
    .z80fi_insn_err (z80fi_insn_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an open instruction is a byte list plus its start pc.
  bit              m_open;
  logic [7:0]      m_bytes[$];
  logic [15:0]     m_pc;
  bit              m_err, m_orphan;
  bit              e_valid;
  logic [31:0]     e_insn;
  logic [2:0]      e_len;
  logic [15:0]     e_pc;
  bit              e_err;

  task automatic model_reset();
    m_open = 0; m_bytes.delete(); m_pc = 0; m_err = 0; m_orphan = 0;
    e_valid = 0; e_insn = 0; e_len = 0; e_pc = 0; e_err = 0;
  endtask

  task automatic emit_pkt(input bit err);
    e_valid = 1;
    e_insn  = 0;
    foreach (m_bytes[i]) e_insn[i*8 +: 8] = m_bytes[i];
    e_len = 3'(m_bytes.size());
    e_pc  = m_pc;
    e_err = err;
  endtask

  task automatic open_new(input logic [15:0] a, input logic [7:0] d);
    m_open = 1;
    m_bytes.delete();
    m_bytes.push_back(d);
    m_pc = a;
    m_err = m_orphan;
    m_orphan = 0;
  endtask

  task automatic model_step(input bit fv, input bit ff, input logic [15:0] a,
                            input logic [7:0] d, input bit ret);
    e_valid = 0;
    if (!m_open) begin
      if (fv && ff) open_new(a, d);
      else if (fv) m_orphan = 1;
    end else if (fv && ff) begin
      emit_pkt(m_err || !ret);
      open_new(a, d);
    end else begin
      if (fv) begin
        if (m_bytes.size() == MAX_LEN) m_err = 1;
        else begin
`ifdef Z80FI_INSN_CAPTURE_CHECK_EN
          if (a != 16'(m_pc + m_bytes.size())) m_err = 1;
`endif
          m_bytes.push_back(d);
        end
      end
      if (ret) begin
        emit_pkt(m_err);
        m_open = 0;
      end
    end
  endtask

  // One clock: compare outputs against the model, then apply the next inputs.
  task automatic cyc(input bit fv, input bit ff, input logic [15:0] a,
                     input logic [7:0] d, input bit ret, input bit rst = 0);
    @(negedge clk);
    check("valid", 64'(z80fi_valid), 64'(e_valid));
    check("insn",  64'(z80fi_insn), 64'(e_insn));
    check("len",   64'(z80fi_insn_len), 64'(e_len));
    check("pc",    64'(z80fi_pc_rdata), 64'(e_pc));
    check("err",   64'(z80fi_insn_err), 64'(e_err));
    fetch_valid = fv; fetch_first = ff; fetch_addr = a; fetch_data = d; retire = ret;
    reset = rst;
    if (rst) model_reset();
    else model_step(fv, ff, a, d, ret);
  endtask

  task automatic expect_pkt(input string tag, input logic [31:0] insn, input logic [2:0] len,
                            input logic [15:0] pc, input bit err);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(z80fi_valid), 64'd1);
    check({tag, "_insn"},  64'(z80fi_insn), 64'(insn));
    check({tag, "_len"},   64'(z80fi_insn_len), 64'(len));
    check({tag, "_pc"},    64'(z80fi_pc_rdata), 64'(pc));
    check({tag, "_err"},   64'(z80fi_insn_err), 64'(err));
  endtask

  logic [15:0] seq_addr;

  initial begin
    reset = 1; fetch_valid = 0; fetch_first = 0; fetch_addr = 0; fetch_data = 0; retire = 0;
    model_reset();
    cyc(0, 0, 16'h0, 8'h0, 0, 1);
    cyc(0, 0, 16'h0, 8'h0, 0);

    // LD BC,1234h with a wait cycle
    cyc(1, 1, 16'h0100, 8'h01, 0);
    cyc(1, 0, 16'h0101, 8'h34, 0);
    cyc(0, 0, 16'h0000, 8'h56, 0);
    cyc(1, 0, 16'h0102, 8'h12, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("ldbc", 32'h00123401, 3'd3, 16'h0100, 0);

    // NOP at FFFF, then address wrap into 0000
    cyc(1, 1, 16'hFFFF, 8'h00, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("nop", 32'h0, 3'd1, 16'hFFFF, 0);
    cyc(1, 1, 16'h0000, 8'h3E, 0);
    cyc(1, 0, 16'h0001, 8'h7F, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("wrap", 32'h00007F3E, 3'd2, 16'h0000, 0);

    // Overflow past MAX_LEN
    cyc(1, 1, 16'h1000, 8'hDD, 0);
    cyc(1, 0, 16'h1001, 8'hCB, 0);
    cyc(1, 0, 16'h1002, 8'h05, 0);
    cyc(1, 0, 16'h1003, 8'h46, 0);
    cyc(1, 0, 16'h1004, 8'h00, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("ovf", 32'h4605CBDD, 3'd4, 16'h1000, 1);

    // Back-to-back: retire with new first byte
    cyc(1, 1, 16'h01F0, 8'h00, 0);
    cyc(1, 1, 16'h0200, 8'h3C, 1);
    expect_pkt("b2b_old", 32'h0, 3'd1, 16'h01F0, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("b2b_new", 32'h3C, 3'd1, 16'h0200, 0);

    // Abandon
    cyc(1, 1, 16'h0300, 8'h01, 0);
    cyc(1, 1, 16'h0301, 8'h00, 0);
    expect_pkt("abandon", 32'h01, 3'd1, 16'h0300, 1);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("after_abandon", 32'h0, 3'd1, 16'h0301, 0);

    // Orphan byte in idle taints the next packet
    cyc(1, 0, 16'h0555, 8'h77, 0);
    cyc(1, 1, 16'h0600, 8'hC9, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("orphan", 32'hC9, 3'd1, 16'h0600, 1);

`ifdef Z80FI_INSN_CAPTURE_CHECK_EN
    cyc(1, 1, 16'h0500, 8'hAA, 0);
    cyc(1, 0, 16'h0507, 8'hBB, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    expect_pkt("badaddr", 32'hBBAA, 3'd2, 16'h0500, 1);
`endif

    // Reset mid-collect
    cyc(1, 1, 16'h0400, 8'h11, 0);
    cyc(1, 0, 16'h0401, 8'h22, 0);
    cyc(0, 0, 16'h0000, 8'h00, 0, 1);
    @(posedge clk); #1;
    check("rst_insn", 64'(z80fi_insn), 64'd0);
    check("rst_len", 64'(z80fi_insn_len), 64'd0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    @(posedge clk); #1;
    check("rst_noemit", 64'(z80fi_valid), 64'd0);

    // Randomized traffic
    seq_addr = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      bit fv, ff, ret, rst;
      logic [15:0] a;
      fv  = ($urandom_range(0, 9) < 6);
      ff  = fv && ($urandom_range(0, 3) == 0);
      ret = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 199) == 0);
      a   = 16'($urandom);
      if (ff) seq_addr = a + 16'd1;
      else if (fv) begin
        if ($urandom_range(0, 9) != 0) a = seq_addr;
        seq_addr = seq_addr + 16'd1;
      end
      cyc(fv, ff, a, 8'($urandom), ret, rst);
    end
    cyc(0, 0, 16'h0, 8'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
